// File: rtl/uart_byte_fifo_if.sv
// uart_byte_fifo_if: byte strobe, transmitter handshake and status bundle for
// the echo-path FIFO. The "master" side is the surrounding UART logic (receiver
// strobe, transmitter done pulse, overflow clear). The "slave" side is the FIFO.
interface uart_byte_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic [7:0]          tx_byte;
    logic                tx_start;
    logic                tx_done;
    logic [DEPTH_LOG2:0] level;
    logic                empty;
    logic                full;
    logic                overflow;
    logic                overflow_clr;

    modport master (
        output rx_byte,
        output rx_valid,
        output tx_done,
        output overflow_clr,
        input  tx_byte,
        input  tx_start,
        input  level,
        input  empty,
        input  full,
        input  overflow
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  tx_done,
        input  overflow_clr,
        output tx_byte,
        output tx_start,
        output level,
        output empty,
        output full,
        output overflow
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular byte FIFO between the UART receiver and transmitter
// in the echo path. Received bytes are written on a single-cycle strobe; a
// three-state reader pops one byte at a time into tx_byte, raises tx_start for
// one cycle and waits for tx_done before popping the next byte.
//
// Optional build macro UART_FIFO_DROP_OLDEST_EN: when defined, a write into a
// full FIFO with no same-cycle pop overwrites the oldest stored byte instead of
// dropping the new one (overflow is still flagged). The byte already handed to
// the transmitter is never touched.
module uart_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_byte_fifo_if.slave  bus
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Storage and bookkeeping
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;

    // Reader / transmitter side
    state_t                r_state;
    logic [7:0]            r_tx_byte;
    logic                  r_tx_start;

    // Per-cycle decisions
    logic w_pop;      // reader takes the oldest byte this cycle
    logic w_space;    // room for a write, counting a same-cycle pop
    logic w_wr;       // normal accepted write (level may grow)
    logic w_drop;     // write arrives while full and nothing leaves
    logic w_mem_we;   // storage is written this cycle
    logic w_rd_adv;   // read pointer advances this cycle

    // The reader only pops from IDLE; full/empty come from level, not pointers.
    assign w_pop   = (r_state == S_IDLE) && (r_level != '0);
    assign w_space = (r_level != LEVEL_FULL) || w_pop;
    assign w_wr    = bus.rx_valid && w_space;
    assign w_drop  = bus.rx_valid && !w_space;

`ifdef UART_FIFO_DROP_OLDEST_EN
    // Overwrite-oldest: the write still lands, and the oldest byte is
    // discarded by stepping the read pointer past it. A drop can only happen
    // outside IDLE (IDLE with data always pops), so the two rd_ptr sources
    // never coincide.
    assign w_mem_we = w_wr || w_drop;
    assign w_rd_adv = w_pop || w_drop;
`else
    // Drop-newest: a write into a full FIFO leaves storage untouched.
    assign w_mem_we = w_wr;
    assign w_rd_adv = w_pop;
`endif

    // Storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus.rx_byte;
        end
    end

    // Write and read pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: grows on an accepted write, shrinks on a pop, unchanged when
    // both happen or when a full-FIFO write is dropped/overwrites.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else if (w_wr && !w_pop) begin
            r_level <= r_level + 1'b1;
        end else if (w_pop && !w_wr) begin
            r_level <= r_level - 1'b1;
        end
    end

    // Sticky overflow; a new loss in the same cycle beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Reader FSM: pop into tx_byte, pulse tx_start once, wait for tx_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_byte  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx_start <= 1'b0;
                    if (w_pop) begin
                        r_tx_byte  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_tx_start <= 1'b0;
                    if (bus.tx_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_byte  = r_tx_byte;
    assign bus.tx_start = r_tx_start;
    assign bus.level    = r_level;
    assign bus.empty    = (r_level == '0);
    assign bus.full     = (r_level == LEVEL_FULL);
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb_uart_byte_fifo: directed stimulus for the echo-path byte FIFO. A queue
// based model predicts every output each cycle; literal expectations pin the
// key scenarios (first-byte latency, burst fill, overflow, drain order,
// full-FIFO write during a pop, reset mid-frame, optional overwrite mode).
module tb_uart_byte_fifo;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk;
    logic reset;

    uart_byte_fifo_if #(.DEPTH_LOG2(DL2)) u_if ();

    uart_byte_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];      // bytes waiting, oldest first
    bit         m_busy;      // a frame is with the transmitter
    bit         m_start;     // expected tx_start this cycle
    logic [7:0] m_byte;      // expected tx_byte
    bit         m_ovf;       // expected overflow flag

    // Model step: a free transmitter takes the oldest byte; tx_done only counts
    // after the start cycle; writes fit if there is room once the pop is gone.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_start = 1'b0;
            m_byte  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            bit done_ok;
            done_ok = m_busy && !m_start && (u_if.tx_done == 1'b1);
            m_start = 1'b0;
            if (!m_busy && m_q.size() > 0) begin
                m_byte  = m_q.pop_front();
                m_busy  = 1'b1;
                m_start = 1'b1;
            end else if (done_ok) begin
                m_busy = 1'b0;
            end
            if (u_if.overflow_clr == 1'b1) m_ovf = 1'b0;
            if (u_if.rx_valid == 1'b1) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(u_if.rx_byte);
                end else begin
                    m_ovf = 1'b1;
`ifdef UART_FIFO_DROP_OLDEST_EN
                    void'(m_q.pop_front());
                    m_q.push_back(u_if.rx_byte);
`endif
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (reset == 1'b0) begin
            chk("cyc_tx_start", 32'(u_if.tx_start), 32'(m_start));
            chk("cyc_tx_byte",  32'(u_if.tx_byte),  32'(m_byte));
            chk("cyc_level",    32'(u_if.level),    32'(m_q.size()));
            chk("cyc_empty",    32'(u_if.empty),    32'(m_q.size() == 0));
            chk("cyc_full",     32'(u_if.full),     32'(m_q.size() == DEPTH));
            chk("cyc_overflow", 32'(u_if.overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] cap [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge; waits (bounded) for tx_start and captures tx_byte.
    task automatic wait_start(output logic [7:0] b);
        int n;
        n = 0;
        while (u_if.tx_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_seen", 32'(u_if.tx_start), 32'd1);
        b = u_if.tx_byte;
    endtask

    // Answer the frame in flight with tx_done two cycles after its start, then
    // collect the next n frames the same way. Optionally write 8'h55 in the
    // first IDLE pop cycle (FIFO full at that moment).
    task automatic drain(input int n, input bit inject);
        for (int f = 0; f < n; f++) begin
            tick();
            tick();
            u_if.tx_done = 1'b1;
            tick();
            u_if.tx_done = 1'b0;
            if (inject && f == 0) begin
                u_if.rx_byte  = 8'h55;
                u_if.rx_valid = 1'b1;
                tick();
                u_if.rx_valid = 1'b0;
                @(negedge clk);
                chk("full_pop_write_level", 32'(u_if.level), 32'd16);
                chk("full_pop_write_ovf",   32'(u_if.overflow), 32'd0);
            end else begin
                @(negedge clk);
            end
            wait_start(cap[f]);
        end
    endtask

    initial begin
        u_if.rx_byte      = 8'h00;
        u_if.rx_valid     = 1'b0;
        u_if.tx_done      = 1'b0;
        u_if.overflow_clr = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_level",    32'(u_if.level),    32'd0);
        chk("rst_empty",    32'(u_if.empty),    32'd1);
        chk("rst_full",     32'(u_if.full),     32'd0);
        chk("rst_overflow", 32'(u_if.overflow), 32'd0);
        chk("rst_tx_byte",  32'(u_if.tx_byte),  32'h00);
        chk("rst_tx_start", 32'(u_if.tx_start), 32'd0);

        // Single write 8'h41: level=1 at N+1, tx_start with 8'h41 at N+2
        tick();
        u_if.rx_byte  = 8'h41;
        u_if.rx_valid = 1'b1;
        tick();
        u_if.rx_valid = 1'b0;
        @(negedge clk);
        chk("single_level_n1", 32'(u_if.level), 32'd1);
        tick();
        @(negedge clk);
        chk("single_tx_start", 32'(u_if.tx_start), 32'd1);
        chk("single_tx_byte",  32'(u_if.tx_byte),  32'h41);
        chk("single_level_n2", 32'(u_if.level),    32'd0);
        repeat (9) tick();
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_idle_no_start", 32'(u_if.tx_start), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("single_byte_held", 32'(u_if.tx_byte), 32'h41);
        chk("single_empty",     32'(u_if.empty),   32'd1);

`ifndef UART_FIFO_DROP_OLDEST_EN
        // Burst 8'h00..8'h11 with tx_done withheld
        for (int k = 0; k < 18; k++) begin
            u_if.rx_byte  = 8'(k);
            u_if.rx_valid = 1'b1;
            tick();
            @(negedge clk);
            if (k == 15) begin
                chk("burst_peak_level", 32'(u_if.level), 32'd15);
                chk("burst_not_full",   32'(u_if.full),  32'd0);
            end
            if (k == 16) begin
                chk("burst17_level", 32'(u_if.level),    32'd16);
                chk("burst17_full",  32'(u_if.full),     32'd1);
                chk("burst17_ovf",   32'(u_if.overflow), 32'd0);
            end
            if (k == 17) begin
                chk("burst18_level", 32'(u_if.level),    32'd16);
                chk("burst18_ovf",   32'(u_if.overflow), 32'd1);
            end
        end
        u_if.rx_valid     = 1'b0;
        u_if.overflow_clr = 1'b1;
        tick();
        u_if.overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(u_if.overflow), 32'd0);

        // Drain: 8'h00 already in flight; 8'h01..8'h10 stored, plus 8'h55
        drain(17, 1'b1);
        for (int f = 0; f < 16; f++) begin
            chk("drain_order", 32'(cap[f]), 32'(f + 1));
        end
        chk("drain_last_injected", 32'(cap[16]), 32'h55);
`else
        // Overwrite-oldest: 8'hEE in flight, 8'h00..8'h0F stored, then 8'hAA
        u_if.rx_byte  = 8'hEE;
        u_if.rx_valid = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            u_if.rx_byte = 8'(k);
            tick();
        end
        u_if.rx_byte = 8'hAA;
        tick();
        u_if.rx_valid = 1'b0;
        @(negedge clk);
        chk("dropold_level",    32'(u_if.level),    32'd16);
        chk("dropold_overflow", 32'(u_if.overflow), 32'd1);
        chk("dropold_inflight", 32'(u_if.tx_byte),  32'hEE);
        drain(16, 1'b0);
        for (int f = 0; f < 15; f++) begin
            chk("dropold_order", 32'(cap[f]), 32'(f + 1));
        end
        chk("dropold_last", 32'(cap[15]), 32'hAA);
`endif

        // Finish the last frame, FIFO ends empty and idle
        tick();
        tick();
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("drained_empty",    32'(u_if.empty),    32'd1);
        chk("drained_no_start", 32'(u_if.tx_start), 32'd0);

        // Reset while in WAIT with level=5
        tick();
        for (int k = 0; k < 6; k++) begin
            u_if.rx_byte  = 8'(8'h60 + k);
            u_if.rx_valid = 1'b1;
            tick();
        end
        u_if.rx_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("prerst_level",   32'(u_if.level),   32'd5);
        chk("prerst_tx_byte", 32'(u_if.tx_byte), 32'h60);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("asyncrst_tx_start", 32'(u_if.tx_start), 32'd0);
        chk("asyncrst_level",    32'(u_if.level),    32'd0);
        chk("asyncrst_empty",    32'(u_if.empty),    32'd1);
        chk("asyncrst_tx_byte",  32'(u_if.tx_byte),  32'h00);
        tick();
        reset = 1'b0;
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_no_start", 32'(u_if.tx_start), 32'd0);
            chk("postrst_level",    32'(u_if.level),    32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
